// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader (byte-stream to instruction-memory writer).
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CHK,
    DONE,
    ERR
  } t_loader_state;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader.sv
// Program loader: assembles big-endian 16-bit words from a byte stream into instruction memory
// and holds the CPU in reset until a full image arrives. Optional checksum byte: LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output t_loader_state     dbg_state
);

  localparam logic [8:0] DEPTH = 9'(2 ** ADDR_W);

  t_loader_state state;
  logic [8:0]    n_words;
  logic [8:0]    word_cnt;
  logic [7:0]    hi_byte;
  logic          take;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    chk_sum;
`endif

  assign dbg_state = state;

  // Handshake: a byte moves when in_valid & in_ready at a rising edge. in_ready is low
  // while load_req is high so the restart never swallows a byte.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE, LEN, HI, LO, CHK: in_ready = ~load_req;
      default:                in_ready = 1'b0;
    endcase
  end

  assign take = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      imem_wr    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_words    <= '0;
      word_cnt   <= '0;
      hi_byte    <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_sum    <= '0;
`endif
    end else if (load_req) begin
      state     <= IDLE;
      imem_wr   <= 1'b0;
      imem_addr <= '0;
      word_cnt  <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      imem_wr <= 1'b0;
      // Advance the address after each write, except after the final word so it never wraps.
      if (imem_wr && state == HI) imem_addr <= imem_addr + ADDR_W'(1);
      case (state)
        IDLE: if (take && in_data == SYNC_BYTE) state <= LEN;
        LEN: if (take) begin
          if (in_data == 8'd0 || {1'b0, in_data} > DEPTH) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            n_words   <= {1'b0, in_data};
            word_cnt  <= '0;
            imem_addr <= '0;
            state     <= HI;
`ifdef LOADER_CHECKSUM_EN
            chk_sum   <= in_data;
`endif
          end
        end
        HI: if (take) begin
          hi_byte <= in_data;
          state   <= LO;
`ifdef LOADER_CHECKSUM_EN
          chk_sum <= chk_sum + in_data;
`endif
        end
        LO: if (take) begin
          imem_wdata <= {hi_byte, in_data};
          imem_wr    <= 1'b1;
          word_cnt   <= word_cnt + 9'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_sum    <= chk_sum + in_data;
`endif
          if (word_cnt + 9'd1 == n_words) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
`endif
          end else begin
            state <= HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (take) begin
          if (in_data == chk_sum) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
`endif
        DONE, ERR: state <= state;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; expected writes come from frame contents.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_wr;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  t_loader_state     dbg_state;

  logic [ADDR_W+15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_wr(imem_wr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin : monitor
    logic [ADDR_W+15:0] e;
    if (imem_wr === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%h, want no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: got addr=%0h data=%h, want addr=%0h data=%h",
                   imem_addr, imem_wdata, e[ADDR_W+15:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random idles.
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int waited;
    waited = 0;
    @(negedge clk);
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: got in_ready=0, want 1 for byte %h", b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] prefix[$], input logic [15:0] words[$],
                           input int gap_mode, input bit bad_chk, input string name);
    logic [7:0] bytes[$];
    logic [7:0] sum;
    bit         exp_ok;
    bytes = prefix;
    bytes.push_back(SYNC_BYTE);
    bytes.push_back(8'(words.size()));
    sum = 8'(words.size());
    foreach (words[i]) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
      sum = sum + words[i][15:8] + words[i][7:0];
      exp_q.push_back({ADDR_W'(i), words[i]});
    end
    exp_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    bytes.push_back(bad_chk ? sum + 8'd1 : sum);
    exp_ok = !bad_chk;
`else
    if (bad_chk) $display("note: %s carries no checksum byte in this build (sum %h)", name, sum);
`endif
    foreach (bytes[i]) send_byte(bytes[i], gap_mode);
    #1;
    check({name, "_done"}, 32'(done), 32'(exp_ok));
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_ok));
    check({name, "_error"}, 32'(error), 32'(!exp_ok));
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_load_req(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    load_req = 1'b1;
    #1;
    check({name, "_ready_during_req"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    load_req = 1'b0;
    #1;
    check({name, "_state_idle"}, 32'(dbg_state), 32'(IDLE));
    check({name, "_flags"}, {29'd0, done, error, cpu_rst}, 32'b001);
    check({name, "_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin
    logic [7:0]  pq[$];
    logic [7:0]  none[$];
    logic [15:0] wq[$];
    int          n;

    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {imem_wr, imem_wdata, cpu_rst, done, error, in_ready},
          {1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    check("reset_addr", 32'(imem_addr), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // Two-word image
    wq.delete(); wq.push_back(16'h3005); wq.push_back(16'h2012);
    run_frame(none, wq, 0, 1'b0, "t1");
    pulse_load_req("t1_restart");

    // Junk before sync is ignored
    pq.delete(); pq.push_back(8'h00); pq.push_back(8'hFF);
    wq.delete(); wq.push_back(16'h7000);
    run_frame(pq, wq, 0, 1'b0, "t2");
    pulse_load_req("t2_restart");

    // Zero length rejected
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h00, 0);
    #1;
    check("t3_error", {29'd0, error, cpu_rst, in_ready}, 32'b110);
    check("t3_done", 32'(done), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    pulse_load_req("t3_restart");

    // load_req mid-frame with a coincident byte
    exp_q.push_back({ADDR_W'(0), 16'h1122});
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h33; load_req = 1'b1;
    #1;
    check("t4_ready_blocked", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; load_req = 1'b0;
    #1;
    check("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    check("t4_addr", 32'(imem_addr), 32'd0);
    wq.delete(); wq.push_back(16'h4000);
    run_frame(none, wq, 0, 1'b0, "t4");
    pulse_load_req("t4_restart");

    // Valid toggling every other cycle
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    run_frame(none, wq, 1, 1'b0, "t5");
    pulse_load_req("t5_restart");

    // Reset mid-load keeps written word, returns to IDLE
    exp_q.push_back({ADDR_W'(0), 16'hABCD});
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_flags", {28'd0, imem_wr, cpu_rst, done, error}, 32'b0100);
    rst = 1'b0;

    // Random images
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 12);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      run_frame(none, wq, 2, 1'b0, $sformatf("rand%0d", f));
      pulse_load_req($sformatf("rand%0d_restart", f));
    end

    // Largest encodable image reaches the top addresses
    wq.delete();
    for (int i = 0; i < 255; i++) wq.push_back(16'($urandom));
    run_frame(none, wq, 0, 1'b0, "max_len");
    pulse_load_req("max_len_restart");

`ifdef LOADER_CHECKSUM_EN
    wq.delete(); wq.push_back(16'h1234);
    run_frame(none, wq, 0, 1'b0, "t6_good");
    pulse_load_req("t6_good_restart");
    run_frame(none, wq, 0, 1'b1, "t6_bad");
    pulse_load_req("t6_bad_restart");
`endif

    repeat (5) @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
